// File: rtl/bp_train_scheduler_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bp_pkg : shared types and constants for the perceptron trainer     |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
package bp_pkg;

  localparam int BP_IDX_W     = 5;
  localparam int BP_HISTORY   = 8;
  // Classic perceptron threshold floor(1.93*h + 14), in integer arithmetic.
  localparam int BP_THETA_DEF = (193 * BP_HISTORY) / 100 + 14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    LRN  = 2'd2,
    WR   = 2'd3
  } train_state_e;

  // Queued request layout at the default geometry; the scheduler packs its
  // FIFO entries in this same {idx, ghr, taken, pred} order.
  typedef struct packed {
    logic [BP_IDX_W-1:0]   idx;
    logic [BP_HISTORY-1:0] ghr;
    logic                  taken;
    logic                  pred;
  } train_req_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bp_train_scheduler_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bp_train_fifo : synchronous FIFO, extra-MSB pointers for full/empty |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
module bp_train_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  always_comb begin
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty    = (wr_ptr_q == rd_ptr_q);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    head     = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: empty pointers hide stale contents.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/bp_train_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bp_train_scheduler : filters resolved branches and runs read/learn/ |
// | write training on the weight table. Optional: BP_TRAIN_STATS_EN.    |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
module bp_train_scheduler
  import bp_pkg::*;
#(
  parameter int IDX_W    = 5,
  parameter int HISTORY  = 8,
  parameter int WEIGHT_W = 72,
  parameter int SUM_W    = 8,
  parameter int THETA    = 20,
  parameter int QDEPTH   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [IDX_W-1:0]    req_idx,
  input  logic [HISTORY-1:0]  req_ghr,
  input  logic                req_taken,
  input  logic                req_pred,
  input  logic [SUM_W-1:0]    req_sum_mag,
  output logic                tbl_rd_en,
  output logic [IDX_W-1:0]    tbl_addr,
  input  logic [WEIGHT_W-1:0] tbl_rd_data,
  output logic                tbl_wr_en,
  output logic [WEIGHT_W-1:0] tbl_wr_data,
  output logic [WEIGHT_W-1:0] lrn_weight,
  output logic [HISTORY-1:0]  lrn_ghr,
  output logic                lrn_taken,
  output logic                lrn_pred,
  input  logic [WEIGHT_W-1:0] lrn_next,
  input  logic [IDX_W-1:0]    fetch_idx,
  output logic                fetch_hazard,
  output logic                busy
`ifdef BP_TRAIN_STATS_EN
  ,
  output logic [15:0]         stat_trained,
  output logic [15:0]         stat_filtered,
  output logic [15:0]         stat_stall
`endif
);

  localparam int               ENT_W     = IDX_W + HISTORY + 2;
  localparam logic [SUM_W-1:0] THETA_MAG = SUM_W'(THETA);

  train_state_e        state_q, state_d;
  logic [ENT_W-1:0]    work_q, work_d;
  logic [WEIGHT_W-1:0] wr_q, wr_d;
  logic [ENT_W-1:0]    head;
  logic                full, empty, pop, accept, train_needed, push;
  logic [IDX_W-1:0]    work_idx;

  assign work_idx     = work_q[ENT_W-1 -: IDX_W];
  assign req_ready    = !full;
  assign accept       = req_valid && !full;
  assign train_needed = (req_taken != req_pred) || (req_sum_mag <= THETA_MAG);
  assign push         = accept && train_needed;
  assign busy         = (state_q != IDLE) || !empty;
  assign fetch_hazard = (state_q != IDLE) && (fetch_idx == work_idx);

  bp_train_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({req_idx, req_ghr, req_taken, req_pred}),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    wr_d        = wr_q;
    pop         = 1'b0;
    tbl_rd_en   = 1'b0;
    tbl_wr_en   = 1'b0;
    tbl_addr    = '0;
    tbl_wr_data = '0;
    lrn_weight  = '0;
    lrn_ghr     = '0;
    lrn_taken   = 1'b0;
    lrn_pred    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          work_d  = head;
          state_d = RD;
        end
      end
      RD: begin
        tbl_rd_en = 1'b1;
        tbl_addr  = work_idx;
        state_d   = LRN;
      end
      LRN: begin
        lrn_weight = tbl_rd_data;
        lrn_ghr    = work_q[HISTORY+1:2];
        lrn_taken  = work_q[1];
        lrn_pred   = work_q[0];
        wr_d       = lrn_next;
        state_d    = WR;
      end
      WR: begin
        tbl_wr_en   = 1'b1;
        tbl_addr    = work_idx;
        tbl_wr_data = wr_q;
        // Chaining the next pop here keeps back-to-back updates at 3 cycles.
        if (!empty) begin
          pop     = 1'b1;
          work_d  = head;
          state_d = RD;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      work_q  <= '0;
      wr_q    <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      wr_q    <= wr_d;
    end
  end

`ifdef BP_TRAIN_STATS_EN
  logic [15:0] stat_trained_q, stat_trained_d;
  logic [15:0] stat_filtered_q, stat_filtered_d;
  logic [15:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_trained_d  = sat_inc16(stat_trained_q, state_q == WR);
    stat_filtered_d = sat_inc16(stat_filtered_q, accept && !train_needed);
    stat_stall_d    = sat_inc16(stat_stall_q, req_valid && full);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_trained_q  <= '0;
      stat_filtered_q <= '0;
      stat_stall_q    <= '0;
    end else begin
      stat_trained_q  <= stat_trained_d;
      stat_filtered_q <= stat_filtered_d;
      stat_stall_q    <= stat_stall_d;
    end
  end

  assign stat_trained  = stat_trained_q;
  assign stat_filtered = stat_filtered_q;
  assign stat_stall    = stat_stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bp_train_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_bp_train_scheduler : directed self-checking bench               |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
module tb_bp_train_scheduler;

  localparam int IDX_W    = 5;
  localparam int HISTORY  = 8;
  localparam int WEIGHT_W = 72;
  localparam int SUM_W    = 8;
  localparam int THETA    = 20;
  localparam int QDEPTH   = 4;

  typedef logic [WEIGHT_W-1:0] w_t;

  logic                clk = 1'b0;
  logic                reset;
  logic                req_valid;
  logic                req_ready;
  logic [IDX_W-1:0]    req_idx;
  logic [HISTORY-1:0]  req_ghr;
  logic                req_taken;
  logic                req_pred;
  logic [SUM_W-1:0]    req_sum_mag;
  logic                tbl_rd_en;
  logic [IDX_W-1:0]    tbl_addr;
  logic [WEIGHT_W-1:0] tbl_rd_data;
  logic                tbl_wr_en;
  logic [WEIGHT_W-1:0] tbl_wr_data;
  logic [WEIGHT_W-1:0] lrn_weight;
  logic [HISTORY-1:0]  lrn_ghr;
  logic                lrn_taken;
  logic                lrn_pred;
  logic [WEIGHT_W-1:0] lrn_next;
  logic [IDX_W-1:0]    fetch_idx;
  logic                fetch_hazard;
  logic                busy;
`ifdef BP_TRAIN_STATS_EN
  logic [15:0]         stat_trained;
  logic [15:0]         stat_filtered;
  logic [15:0]         stat_stall;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int               wr_cyc[$];
  logic [IDX_W-1:0] wr_addr[$];
  w_t               wr_data[$];

  always #5 clk = ~clk;

  bp_train_scheduler #(
    .IDX_W(IDX_W), .HISTORY(HISTORY), .WEIGHT_W(WEIGHT_W),
    .SUM_W(SUM_W), .THETA(THETA), .QDEPTH(QDEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_idx(req_idx),
    .req_ghr(req_ghr), .req_taken(req_taken), .req_pred(req_pred),
    .req_sum_mag(req_sum_mag),
    .tbl_rd_en(tbl_rd_en), .tbl_addr(tbl_addr), .tbl_rd_data(tbl_rd_data),
    .tbl_wr_en(tbl_wr_en), .tbl_wr_data(tbl_wr_data),
    .lrn_weight(lrn_weight), .lrn_ghr(lrn_ghr), .lrn_taken(lrn_taken),
    .lrn_pred(lrn_pred), .lrn_next(lrn_next),
    .fetch_idx(fetch_idx), .fetch_hazard(fetch_hazard), .busy(busy)
`ifdef BP_TRAIN_STATS_EN
    , .stat_trained(stat_trained), .stat_filtered(stat_filtered), .stat_stall(stat_stall)
`endif
  );

  // Every table row starts with a distinct, recognisable pattern.
  function automatic w_t init_row(input logic [IDX_W-1:0] i);
    return {8'(i), 64'h0123_4567_89AB_CDEF ^ 64'(i)};
  endfunction

  // Learner stand-in: adds the training context into the row.
  function automatic w_t learn(input w_t w, input logic [HISTORY-1:0] g,
                               input logic t, input logic p);
    return w + {62'd0, g, t, p};
  endfunction

  assign lrn_next = learn(lrn_weight, lrn_ghr, lrn_taken, lrn_pred);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    tbl_rd_data <= tbl_rd_en ? init_row(tbl_addr) : '0;
    if (tbl_wr_en) begin
      wr_cyc.push_back(cyc);
      wr_addr.push_back(tbl_addr);
      wr_data.push_back(tbl_wr_data);
    end
  end

  task automatic chk(input string tag, input w_t obs, input w_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request and returns in the cycle after it was accepted.
  task automatic send(input int idx, input int ghr, input logic t,
                      input logic p, input int mag);
    int n;
    req_idx     = IDX_W'(idx);
    req_ghr     = HISTORY'(ghr);
    req_taken   = t;
    req_pred    = p;
    req_sum_mag = SUM_W'(mag);
    req_valid   = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      step();
      n++;
    end
    chk("accept_timeout", w_t'(req_ready), w_t'(1));
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    chk("idle_timeout", w_t'(busy), w_t'(0));
  endtask

  initial begin
    reset       = 1'b0;
    req_valid   = 1'b0;
    req_idx     = '0;
    req_ghr     = '0;
    req_taken   = 1'b0;
    req_pred    = 1'b0;
    req_sum_mag = '0;
    fetch_idx   = '0;
    tbl_rd_data = '0;
    step();
    step();
    chk("rst_ready", w_t'(req_ready), w_t'(1));
    chk("rst_busy", w_t'(busy), w_t'(0));
    chk("rst_rd_en", w_t'(tbl_rd_en), w_t'(0));
    chk("rst_wr_en", w_t'(tbl_wr_en), w_t'(0));
    chk("rst_lrn_weight", lrn_weight, w_t'(0));
    reset = 1'b1;
    step();

    // Single mispredict: RD in cycle 2, LRN 3, WR 4, idle in 5.
    send(5, 'hA5, 1'b0, 1'b1, 50);
    chk("t1_c1_busy", w_t'(busy), w_t'(1));
    chk("t1_c1_rd_en", w_t'(tbl_rd_en), w_t'(0));
    step();
    chk("t1_c2_rd_en", w_t'(tbl_rd_en), w_t'(1));
    chk("t1_c2_addr", w_t'(tbl_addr), w_t'(5));
    chk("t1_c2_wr_en", w_t'(tbl_wr_en), w_t'(0));
    step();
    chk("t1_c3_weight", lrn_weight, init_row(5'd5));
    chk("t1_c3_ghr", w_t'(lrn_ghr), w_t'('hA5));
    chk("t1_c3_taken", w_t'(lrn_taken), w_t'(0));
    chk("t1_c3_pred", w_t'(lrn_pred), w_t'(1));
    chk("t1_c3_rd_en", w_t'(tbl_rd_en), w_t'(0));
    step();
    chk("t1_c4_wr_en", w_t'(tbl_wr_en), w_t'(1));
    chk("t1_c4_addr", w_t'(tbl_addr), w_t'(5));
    chk("t1_c4_wr_data", tbl_wr_data, learn(init_row(5'd5), 8'hA5, 1'b0, 1'b1));
    step();
    chk("t1_c5_busy", w_t'(busy), w_t'(0));
    chk("t1_c5_wr_en", w_t'(tbl_wr_en), w_t'(0));

    // Threshold filter: mag 21 is confident and dropped, mag 20 is trained.
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    chk("t2_ready", w_t'(req_ready), w_t'(1));
    send(8, 'h11, 1'b1, 1'b1, 21);
    chk("t2_filt_busy", w_t'(busy), w_t'(0));
    chk("t2_filt_ready", w_t'(req_ready), w_t'(1));
    step();
    step();
    chk("t2_filt_rd_en", w_t'(tbl_rd_en), w_t'(0));
    chk("t2_filt_writes", w_t'(wr_addr.size()), w_t'(0));
    send(9, 'h22, 1'b1, 1'b1, 20);
    wait_idle();
    chk("t2_thr_writes", w_t'(wr_addr.size()), w_t'(1));
    chk("t2_thr_addr", w_t'(wr_addr[0]), w_t'(9));
    chk("t2_thr_data", wr_data[0], learn(init_row(5'd9), 8'h22, 1'b1, 1'b1));

    // Six back-to-back mispredicts fill the 4-deep FIFO.
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    for (int i = 0; i < 6; i++) send(10 + i, 'h40 + i, 1'b1, 1'b0, 100);
    chk("t3_full_ready", w_t'(req_ready), w_t'(0));
    wait_idle();
    chk("t3_writes", w_t'(wr_addr.size()), w_t'(6));
    for (int i = 0; i < 6; i++) begin
      chk("t3_addr", w_t'(wr_addr[i]), w_t'(10 + i));
      chk("t3_data", wr_data[i], learn(init_row(5'(10 + i)), 8'(8'h40 + i), 1'b1, 1'b0));
      if (i > 0) chk("t3_spacing", w_t'(wr_cyc[i] - wr_cyc[i-1]), w_t'(3));
    end

    // Fetch hazard only while a row is in training.
    send(7, 'h33, 1'b0, 1'b1, 0);
    fetch_idx = 5'd9;
    #1;
    chk("t4_idle_hazard", w_t'(fetch_hazard), w_t'(0));
    step();
    step();
    fetch_idx = 5'd7;
    #1;
    chk("t4_lrn_hazard", w_t'(fetch_hazard), w_t'(1));
    fetch_idx = 5'd8;
    #1;
    chk("t4_lrn_nohazard", w_t'(fetch_hazard), w_t'(0));
    wait_idle();

    // Reset during LRN aborts the update.
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    send(3, 'h5C, 1'b1, 1'b0, 5);
    step();
    step();
    chk("t5_in_lrn", w_t'(lrn_ghr), w_t'('h5C));
    reset = 1'b0;
    #1;
    chk("t5_rst_lrn_weight", lrn_weight, w_t'(0));
    chk("t5_rst_lrn_ghr", w_t'(lrn_ghr), w_t'(0));
    chk("t5_rst_rd_en", w_t'(tbl_rd_en), w_t'(0));
    chk("t5_rst_wr_en", w_t'(tbl_wr_en), w_t'(0));
    chk("t5_rst_busy", w_t'(busy), w_t'(0));
    chk("t5_rst_ready", w_t'(req_ready), w_t'(1));
    step();
    step();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("t5_no_write", w_t'(wr_addr.size()), w_t'(0));
    chk("t5_empty", w_t'(busy), w_t'(0));

    // Ten trickled requests walk the pointers through wrap-around.
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) send(16 + i, i * 29 + 3, 1'b0, 1'b1, 200);
      else            send(16 + i, i * 29 + 3, 1'b1, 1'b1, i);
      wait_idle();
      chk("t6_ready", w_t'(req_ready), w_t'(1));
    end
    chk("t6_writes", w_t'(wr_addr.size()), w_t'(10));
    for (int i = 0; i < 10; i++) begin
      chk("t6_addr", w_t'(wr_addr[i]), w_t'(16 + i));
      chk("t6_data", wr_data[i],
          learn(init_row(5'(16 + i)), 8'(i * 29 + 3), (i % 2 == 1), 1'b1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
